fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode/control stage. It owns the fetch PC and issues requests to instruction memory, tolerating variable memory latency. Returned instructions are buffered in a small instruction queue that decode drains. It consumes next_PC_sel / target_PC from the control stage and produces the i_mem_hazard indication that control uses for stalls.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: control-stage
// next-PC encodings, the NOP word and the fetch state encodings.
package fetch_unit_pkg;

  localparam logic [1:0] NPC_ADVANCE  = 2'b00;
  localparam logic [1:0] NPC_STALL    = 2'b01;
  localparam logic [1:0] NPC_REDIRECT = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // 01 and 11 both mean "hold the queue head".
  function automatic logic npc_holds(input logic [1:0] sel);
    return (sel == NPC_STALL) || (sel == (NPC_STALL | NPC_REDIRECT));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both as the in-flight request tracker and as
// the instruction queue. A flush empties it and discards a same-cycle push;
// push and pop in the same cycle are both performed.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset; count says which entries are meaningful.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues requests to a
// variable-latency instruction memory, tags each request with an epoch so
// responses from before a redirect can be dropped, and buffers returned
// instructions in a small queue drained by decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int ADDRESS_BITS    = 20,
  parameter int QUEUE_DEPTH     = 2,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic [1:0]              next_PC_sel,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    i_mem_read,
  output logic                    fetch_req,
  output logic [ADDRESS_BITS-1:0] fetch_addr,
  input  logic                    fetch_ready,
  input  logic                    fetch_rsp_valid,
  input  logic [31:0]             fetch_rsp_data,
  output logic [31:0]             instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    inst_valid,
  output logic                    i_mem_hazard,
  input  logic                    scan
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int TRK_W = 1 + ADDRESS_BITS;
  localparam int QUE_W = 32 + ADDRESS_BITS;

  logic [0:0]              state_q;
  logic [ADDRESS_BITS-1:0] pc_q;
  logic                    epoch_q;
  logic [ADDRESS_BITS-1:0] expect_pc_q;
  logic [31:0]             cycle_count;

  logic                    run;
  logic                    redirect;
  logic                    credit_ok;
  logic                    accept;
  logic                    rsp_take;
  logic                    q_push;
  logic                    q_pop;

  logic [CNT_W-1:0]        trk_count;
  logic [TRK_W-1:0]        trk_head;
  logic                    trk_epoch;
  logic [ADDRESS_BITS-1:0] trk_pc;

  logic [CNT_W-1:0]        q_count;
  logic [QUE_W-1:0]        q_head;

  assign run       = (state_q == RUN);
  assign redirect  = run && (next_PC_sel == NPC_REDIRECT);
  assign credit_ok = ({1'b0, trk_count} + {1'b0, q_count}) < (CNT_W+1)'(QUEUE_DEPTH);

  assign fetch_req  = run && i_mem_read && credit_ok && (next_PC_sel != NPC_REDIRECT);
  assign fetch_addr = pc_q;
  assign accept     = fetch_req && fetch_ready;

  assign trk_epoch = trk_head[ADDRESS_BITS];
  assign trk_pc    = trk_head[ADDRESS_BITS-1:0];

  // A response always retires its tracker entry; it only reaches the queue
  // when it belongs to the current path and no redirect is happening now.
  assign rsp_take = fetch_rsp_valid && (trk_count != '0);
  assign q_push   = rsp_take && (trk_epoch == epoch_q) && !redirect;
  assign q_pop    = run && inst_valid && (next_PC_sel == NPC_ADVANCE);

  assign inst_valid   = (q_count != '0);
  assign instruction  = inst_valid ? q_head[31:0] : NOP;
  assign inst_PC      = inst_valid ? q_head[QUE_W-1:32] : expect_pc_q;
  assign i_mem_hazard = run && !inst_valid;

  fetch_fifo #(
    .WIDTH (TRK_W),
    .DEPTH (QUEUE_DEPTH)
  ) tracker (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (accept),
    .pop       (rsp_take),
    .push_data ({epoch_q, pc_q}),
    .count     (trk_count),
    .head      (trk_head)
  );

  fetch_fifo #(
    .WIDTH (QUE_W),
    .DEPTH (QUEUE_DEPTH)
  ) inst_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (q_push),
    .pop       (q_pop),
    .push_data ({trk_pc, fetch_rsp_data}),
    .count     (q_count),
    .head      (q_head)
  );

  // Fetch state, PC, epoch and the PC decode should expect next.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      epoch_q     <= 1'b0;
      expect_pc_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_q     <= RUN;
        pc_q        <= program_address;
        expect_pc_q <= program_address;
      end
    end else if (redirect) begin
      pc_q        <= target_PC;
      epoch_q     <= ~epoch_q;
      expect_pc_q <= target_PC;
    end else begin
      if (accept) pc_q <= pc_q + ADDRESS_BITS'(4);
      if (q_push) expect_pc_q <= trk_pc + ADDRESS_BITS'(4);
    end
  end

  // Free-running cycle counter that frames the debug print window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_count <= '0;
    else        cycle_count <= cycle_count + 32'd1;
  end

`ifndef SYNTHESIS
  rsp_needs_tracker: assert property (@(posedge clock) disable iff (!reset)
    fetch_rsp_valid |-> (trk_count != '0));

  // Debug trace of the fetch state while scan is on and inside the window.
  always @(posedge clock) begin
    if (scan && ($signed(cycle_count) >= SCAN_CYCLES_MIN) &&
        ($signed(cycle_count) <= SCAN_CYCLES_MAX)) begin
      $display("[fetch%0d] cyc=%0d state=%s pc=%h epoch=%0d trk=%0d q=%0d inst=%h inst_pc=%h hazard=%0d hold=%0d",
               CORE, cycle_count, run ? "RUN" : "IDLE", pc_q, epoch_q,
               trk_count, q_count, instruction, inst_PC, i_mem_hazard,
               npc_holds(next_PC_sel));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order instruction memory
// whose latency is set per test. Expected values are hand-computed.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [19:0] program_address;
  logic [1:0]  next_PC_sel;
  logic [19:0] target_PC;
  logic        i_mem_read;
  logic        fetch_req;
  logic [19:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_rsp_valid;
  logic [31:0] fetch_rsp_data;
  logic [31:0] instruction;
  logic [19:0] inst_PC;
  logic        inst_valid;
  logic        i_mem_hazard;
  logic        scan;

  int tests_run;
  int tests_failed;
  int edge_cnt;
  int mem_latency;
  logic inject_beef;

  logic [19:0] pend_addr[$];
  int          pend_due[$];

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .program_address (program_address),
    .next_PC_sel     (next_PC_sel),
    .target_PC       (target_PC),
    .i_mem_read      (i_mem_read),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_ready     (fetch_ready),
    .fetch_rsp_valid (fetch_rsp_valid),
    .fetch_rsp_data  (fetch_rsp_data),
    .instruction     (instruction),
    .inst_PC         (inst_PC),
    .inst_valid      (inst_valid),
    .i_mem_hazard    (i_mem_hazard),
    .scan            (scan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt = edge_cnt + 1;

  function automatic logic [31:0] mem_data(input logic [19:0] addr);
    return {12'hC0D, addr};
  endfunction

  // Memory model: updates mid-cycle so it sees settled requests and its
  // response is stable for the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      pend_addr.delete();
      pend_due.delete();
      fetch_rsp_valid = 1'b0;
      fetch_rsp_data  = 32'h0;
    end else begin
      fetch_rsp_valid = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] == edge_cnt + 1) begin
        fetch_rsp_valid = 1'b1;
        fetch_rsp_data  = inject_beef ? 32'hDEADBEEF : mem_data(pend_addr[0]);
        inject_beef     = 1'b0;
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (fetch_req && fetch_ready) begin
        pend_addr.push_back(fetch_addr);
        pend_due.push_back(edge_cnt + 1 + mem_latency);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [19:0] tgt);
    next_PC_sel = sel;
    target_PC   = tgt;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    start       = 1'b0;
    inject_beef = 1'b0;
    i_mem_read  = 1'b1;
    applyStimulus(2'b00, 20'h0);
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic do_start(input logic [19:0] addr, input int lat);
    mem_latency     = lat;
    program_address = addr;
    start           = 1'b1;
    step();
    start           = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    edge_cnt        = 0;
    mem_latency     = 1;
    inject_beef     = 1'b0;
    reset           = 1'b0;
    start           = 1'b0;
    program_address = 20'h0;
    next_PC_sel     = 2'b00;
    target_PC       = 20'h0;
    i_mem_read      = 1'b1;
    fetch_ready     = 1'b1;
    fetch_rsp_valid = 1'b0;
    fetch_rsp_data  = 32'h0;
    scan            = 1'b0;

    // Reset state
    repeat (3) step();
    checkOutput("rst_fetch_req", fetch_req, 0);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_instruction", instruction, NOP_WORD);
    checkOutput("rst_inst_PC", inst_PC, 0);
    checkOutput("rst_hazard", i_mem_hazard, 0);
    reset = 1'b1;
    step();
    checkOutput("idle_fetch_req", fetch_req, 0);
    checkOutput("idle_hazard", i_mem_hazard, 0);

    // Boot from 0x00100 with 1-cycle memory, then stall and drain
    do_start(20'h00100, 1);
    checkOutput("boot_req", fetch_req, 1);
    checkOutput("boot_addr0", fetch_addr, 20'h00100);
    checkOutput("boot_valid0", inst_valid, 0);
    checkOutput("boot_hazard0", i_mem_hazard, 1);
    checkOutput("boot_inst_PC0", inst_PC, 20'h00100);
    step();
    checkOutput("boot_addr1", fetch_addr, 20'h00104);
    checkOutput("boot_valid1", inst_valid, 0);
    step();
    checkOutput("boot_valid2", inst_valid, 1);
    checkOutput("boot_inst_PC2", inst_PC, 20'h00100);
    checkOutput("boot_instr2", instruction, mem_data(20'h00100));
    checkOutput("credit_req", fetch_req, 0);
    applyStimulus(2'b01, 20'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stall_inst_PC", inst_PC, 20'h00100);
      checkOutput("stall_req", fetch_req, 0);
    end
    applyStimulus(2'b00, 20'h0);
    step();
    checkOutput("drain_inst_PC1", inst_PC, 20'h00104);
    checkOutput("drain_req", fetch_req, 1);
    checkOutput("drain_addr", fetch_addr, 20'h00108);
    step();
    checkOutput("drain_empty", inst_valid, 0);
    checkOutput("drain_empty_PC", inst_PC, 20'h00108);
    checkOutput("drain_hazard", i_mem_hazard, 1);
    step();
    checkOutput("drain_valid", inst_valid, 1);
    checkOutput("drain_inst_PC2", inst_PC, 20'h00108);
    checkOutput("drain_instr2", instruction, mem_data(20'h00108));

    // Redirect with two stale requests in flight, 3-cycle memory
    do_reset();
    do_start(20'h00100, 3);
    step();
    step();
    checkOutput("redir_credit_req", fetch_req, 0);
    applyStimulus(2'b10, 20'h00400);
    step();
    applyStimulus(2'b00, 20'h0);
    checkOutput("redir_flush", inst_valid, 0);
    checkOutput("redir_inst_PC", inst_PC, 20'h00400);
    checkOutput("redir_req_wait", fetch_req, 0);
    step();
    checkOutput("redir_req", fetch_req, 1);
    checkOutput("redir_addr", fetch_addr, 20'h00400);
    checkOutput("redir_stale0", inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("redir_stale", inst_valid, 0);
    end
    step();
    checkOutput("redir_valid", inst_valid, 1);
    checkOutput("redir_new_PC", inst_PC, 20'h00400);
    checkOutput("redir_new_instr", instruction, mem_data(20'h00400));

    // Redirect in the same cycle as a response
    do_reset();
    do_start(20'h00100, 1);
    step();
    checkOutput("coin_req_pre", fetch_req, 1);
    checkOutput("coin_addr_pre", fetch_addr, 20'h00104);
    applyStimulus(2'b10, 20'h00400);
    inject_beef = 1'b1;
    checkOutput("coin_req_redirect", fetch_req, 0);
    step();
    applyStimulus(2'b00, 20'h0);
    checkOutput("coin_dropped", inst_valid, 0);
    checkOutput("coin_hazard0", i_mem_hazard, 1);
    checkOutput("coin_inst_PC", inst_PC, 20'h00400);
    checkOutput("coin_addr", fetch_addr, 20'h00400);
    checkOutput("coin_req", fetch_req, 1);
    step();
    checkOutput("coin_hazard1", i_mem_hazard, 1);
    checkOutput("coin_valid1", inst_valid, 0);
    step();
    checkOutput("coin_valid2", inst_valid, 1);
    checkOutput("coin_new_PC", inst_PC, 20'h00400);
    checkOutput("coin_new_instr", instruction, mem_data(20'h00400));
    checkOutput("coin_hazard2", i_mem_hazard, 0);

    // PC wrap at the top of the address space
    do_reset();
    do_start(20'hFFFFC, 1);
    checkOutput("wrap_addr0", fetch_addr, 20'hFFFFC);
    step();
    checkOutput("wrap_addr1", fetch_addr, 20'h00000);
    checkOutput("wrap_req1", fetch_req, 1);
    step();
    checkOutput("wrap_inst_PC0", inst_PC, 20'hFFFFC);
    checkOutput("wrap_instr0", instruction, mem_data(20'hFFFFC));
    step();
    checkOutput("wrap_inst_PC1", inst_PC, 20'h00000);
    checkOutput("wrap_instr1", instruction, mem_data(20'h00000));
    checkOutput("wrap_req_on", fetch_req, 1);
    i_mem_read = 1'b0;
    #1;
    checkOutput("imem_read_off", fetch_req, 0);
    i_mem_read = 1'b1;

    // Asynchronous reset in the middle of a run
    do_reset();
    do_start(20'h00100, 2);
    step();
    step();
    step();
    checkOutput("async_pre_valid", inst_valid, 1);
    reset = 1'b0;
    #1;
    checkOutput("async_valid", inst_valid, 0);
    checkOutput("async_req", fetch_req, 0);
    checkOutput("async_instr", instruction, NOP_WORD);
    checkOutput("async_inst_PC", inst_PC, 0);
    checkOutput("async_hazard", i_mem_hazard, 0);
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("post_rst_valid", inst_valid, 0);
      checkOutput("post_rst_req", fetch_req, 0);
    end
    do_start(20'h00200, 1);
    checkOutput("restart_addr", fetch_addr, 20'h00200);
    step();
    step();
    checkOutput("restart_valid", inst_valid, 1);
    checkOutput("restart_inst_PC", inst_PC, 20'h00200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
